saph_fpu_resq: RTL and testbench

Result-side collector for the FPU issue/result interface. It observes op issues per FPU lane, carries each issue's tag through a latency-matched shadow pipeline, and pairs it with the result strobe the FPU returns. It also queues results from all lanes into one in-order FIFO with a valid/ready consumer port. Issue is gated by a credit signal, so the FIFO can never overflow.

---
 rtl/saph_fpu_resq.sv | 132 +++++++++++++
 tb/tb_saph_fpu_resq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/saph_fpu_resq.sv
// saph_fpu_resq - FPU result collector: latency-matched tag shadow per lane, credit-gated in-order result FIFO.
// Optional issue/result pairing check enabled by defining SAPH_FPU_RESQ_CHECK_EN.
module saph_fpu_resq #(
   parameter int  LANES   = 2,
   parameter int  LATENCY = 2,
   parameter int  DEPTH   = 8,
   parameter int  TAG_W   = 4,
   localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LANES-1:0]       iss_trig,
   input  logic [LANES*TAG_W-1:0] iss_tag,
   output logic                   iss_ok,
   input  logic [LANES-1:0]       res_trig,
   input  logic [LANES*32-1:0]    res_val,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic [TAG_W-1:0]       out_tag,
   output logic [LW-1:0]          out_lane,
   output logic                   err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [LANES-1:0]       sh_v   [LATENCY];
   logic [LANES*TAG_W-1:0] sh_tag [LATENCY];

   logic [31:0]      mem_data [DEPTH];
   logic [TAG_W-1:0] mem_tag  [DEPTH];
   logic [LW-1:0]    mem_lane [DEPTH];

   logic [PW-1:0] wptr, rptr, infl, cnt;
   logic [PW-1:0] n_push, n_iss, n_done;
   logic [AW-1:0] head;
   logic [AW-1:0] push_idx [LANES];
   logic [LANES-1:0]       push_en;
   logic [LANES-1:0]       accepted;
   logic [LANES*TAG_W-1:0] acc_tag;
   logic [LANES-1:0]       dv;
   logic [LANES*TAG_W-1:0] dtag;
   logic drop, mism, pop;

   assign dv   = sh_v[LATENCY-1];
   assign dtag = sh_tag[LATENCY-1];

   always_comb begin
      int n;
      int ni;
      int nd;
      cnt       = wptr - rptr;
      out_valid = (cnt != '0);
      pop       = out_valid && out_ready;
      head      = out_valid ? rptr[AW-1:0] : rptr[AW-1:0] - AW'(1);
      iss_ok    = (32'(cnt) + 32'(infl) + 32'(LANES)) <= 32'(DEPTH);
      accepted  = iss_ok ? iss_trig : '0;
      acc_tag   = '0;
      drop      = 1'b0;
      push_en   = '0;
      n  = 0;
      ni = 0;
      nd = 0;
      // Lanes claim consecutive slots in ascending order; anything past free space is dropped.
      for (int i = 0; i < LANES; i++) begin
         if (accepted[i]) acc_tag[i*TAG_W +: TAG_W] = iss_tag[i*TAG_W +: TAG_W];
         if (accepted[i]) ni++;
         if (dv[i]) nd++;
         push_idx[i] = wptr[AW-1:0] + AW'(n);
         if (res_trig[i]) begin
            if (n + int'(cnt) < DEPTH) begin
               push_en[i] = 1'b1;
               n++;
            end else begin
               drop = 1'b1;
            end
         end
      end
      n_push = PW'(n);
      n_iss  = PW'(ni);
      n_done = PW'(nd);
`ifdef SAPH_FPU_RESQ_CHECK_EN
      mism = |(res_trig ^ dv);
`else
      mism = 1'b0;
`endif
   end

   assign out_data = mem_data[head];
   assign out_tag  = mem_tag[head];
   assign out_lane = mem_lane[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         infl <= '0;
         err  <= 1'b0;
         for (int s = 0; s < LATENCY; s++) begin
            sh_v[s]   <= '0;
            sh_tag[s] <= '0;
         end
         for (int d = 0; d < DEPTH; d++) begin
            mem_data[d] <= '0;
            mem_tag[d]  <= '0;
            mem_lane[d] <= '0;
         end
      end else begin
         sh_v[0]   <= accepted;
         sh_tag[0] <= acc_tag;
         for (int s = 1; s < LATENCY; s++) begin
            sh_v[s]   <= sh_v[s-1];
            sh_tag[s] <= sh_tag[s-1];
         end
         // Unmatched shadow slots carry tag 0, so a result without an issue is queued with tag 0.
         for (int i = 0; i < LANES; i++) begin
            if (push_en[i]) begin
               mem_data[push_idx[i]] <= res_val[i*32 +: 32];
               mem_tag[push_idx[i]]  <= dtag[i*TAG_W +: TAG_W];
               mem_lane[push_idx[i]] <= LW'(i);
            end
         end
         wptr <= wptr + n_push;
         rptr <= rptr + PW'(pop);
         // Retire in-flight ops as their shadow slots reach the compare point.
         infl <= infl + n_iss - n_done;
         err  <= err | ((|iss_trig) & ~iss_ok) | drop | mism;
      end
   end

endmodule

// File: tb/tb_saph_fpu_resq.sv
// tb/tb_saph_fpu_resq.sv - directed self-checking bench for saph_fpu_resq.
module tb_saph_fpu_resq;

   logic        clk;
   logic        rst_n;
   logic [1:0]  iss_trig;
   logic [7:0]  iss_tag;
   logic        iss_ok;
   logic [1:0]  res_trig;
   logic [63:0] res_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic [0:0]  out_lane;
   logic        err;

   int tests = 0;
   int fails = 0;
   logic exp_mism_err;

   saph_fpu_resq dut (
      .clk(clk), .rst_n(rst_n),
      .iss_trig(iss_trig), .iss_tag(iss_tag), .iss_ok(iss_ok),
      .res_trig(res_trig), .res_val(res_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_lane(out_lane),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef SAPH_FPU_RESQ_CHECK_EN
      exp_mism_err = 1'b1;
`else
      exp_mism_err = 1'b0;
`endif
      rst_n = 1'b0; iss_trig = '0; iss_tag = '0; res_trig = '0; res_val = '0; out_ready = 1'b0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_iss_ok", iss_ok, 1);
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_lane", out_lane, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      // single op
      iss_trig = 2'b01; iss_tag = 8'h03;
      tick();
      iss_trig = '0; iss_tag = '0;
      tick();
      res_trig = 2'b01; res_val = {32'h0, 32'h40800000};
      tick();
      res_trig = '0;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 32'h40800000);
      chk("single_tag", out_tag, 3);
      chk("single_lane", out_lane, 0);
      chk("single_err", err, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_popped", out_valid, 0);
      chk("single_hold", out_data, 32'h40800000);

      // dual lane same cycle
      iss_trig = 2'b11; iss_tag = {4'd2, 4'd1};
      tick();
      iss_trig = '0;
      tick();
      res_trig = 2'b11; res_val = {32'h409B3333, 32'hC1600000}; out_ready = 1'b1;
      tick();
      res_trig = '0;
      chk("dual0_data", out_data, 32'hC1600000);
      chk("dual0_tag", out_tag, 1);
      chk("dual0_lane", out_lane, 0);
      tick();
      chk("dual1_valid", out_valid, 1);
      chk("dual1_data", out_data, 32'h409B3333);
      chk("dual1_tag", out_tag, 2);
      chk("dual1_lane", out_lane, 1);
      tick();
      out_ready = 1'b0;
      chk("dual_empty", out_valid, 0);
      chk("dual_err", err, 0);

      // credit exhaustion: FPU model returns each issue pair two cycles later
      for (int c = 0; c < 8; c++) begin
         iss_trig = (c < 4) ? 2'b11 : 2'b00;
         iss_tag  = {4'(2*c+1), 4'(2*c)};
         res_trig = (c >= 2 && c < 6) ? 2'b11 : 2'b00;
         res_val  = {32'hA0000000 + 32'((c-2)*2+1), 32'hA0000000 + 32'((c-2)*2)};
         chk($sformatf("credit_ok_c%0d", c), iss_ok, (c < 4) ? 1 : 0);
         tick();
      end
      iss_trig = '0; res_trig = '0;
      chk("full_valid", out_valid, 1);
      chk("full_err", err, 0);
      chk("full_iss_ok", iss_ok, 0);

      // forced issue without credit
      iss_trig = 2'b11; iss_tag = 8'hFF;
      tick();
      iss_trig = '0;
      chk("ovf_err", err, 1);
      tick();
      tick();

      // drain: exactly the 8 credited entries, in order
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain_valid_%0d", k), out_valid, 1);
         chk($sformatf("drain_tag_%0d", k), out_tag, k);
         chk($sformatf("drain_data_%0d", k), out_data, 32'hA0000000 + 32'(k));
         chk($sformatf("drain_lane_%0d", k), out_lane, k % 2);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", out_valid, 0);
      chk("err_sticky", err, 1);

      // reset mid-flight: 4 queued, 2 in flight
      iss_trig = 2'b11; iss_tag = 8'h65;
      tick();
      tick();
      res_trig = 2'b11; res_val = {32'h11111111, 32'h22222222};
      tick();
      iss_trig = '0;
      tick();
      res_trig = '0;
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_iss_ok", iss_ok, 1);
      chk("async_rst_err", err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_valid", out_valid, 0);

      // result without issue
      res_trig = 2'b10; res_val = {32'h3F800000, 32'h0};
      tick();
      res_trig = '0;
      chk("mism_valid", out_valid, 1);
      chk("mism_tag", out_tag, 0);
      chk("mism_lane", out_lane, 1);
      chk("mism_data", out_data, 32'h3F800000);
      chk("mism_err", err, exp_mism_err);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
